frame_minmax_tracker: RTL and testbench
=======================================

// Module: frame_minmax_tracker
// PURPOSE
//  Sequential consumer of the eight-bit comparator. Accepts a valid/ready stream
//  of unsigned samples and groups them into frames of FRAME_LEN samples.
//  Per frame, it tracks the running maximum and minimum and the index of each,
//  using the cascaded l/e/g comparison (a<b, a=b, a>b).
//  At end of frame, it presents one result record on a valid/ready output port.
// PARAMETERS
//  WIDTH      8   sample width, unsigned
//  FRAME_LEN  16  samples per frame, legal range 2..255
//  IDX_W      8   width of index/count fields, must satisfy 2**IDX_W > FRAME_LEN
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-high; clears all state
//  clear      in   1      synchronous abort: discard partial frame or pending result
//  in_valid   in   1      sample present on in_data
//  in_data    in   WIDTH  sample, unsigned
//  in_ready   out  1      = (state==ACCUM) && !clear  (combinational)
//  out_valid  out  1      result record valid (registered)
//  out_ready  in   1      consumer accepts record
//  max_val    out  WIDTH  frame maximum
//  max_idx    out  IDX_W  index in frame (0-based) of FIRST occurrence of max
//  min_val    out  WIDTH  frame minimum
//  min_idx    out  IDX_W  index in frame of FIRST occurrence of min
//  all_equal  out  1      1 when every sample in the frame equalled sample 0
// BEHAVIOUR
//  - Reset, asynchronous:
//    - state=ACCUM, cnt=0, out_valid=0
//    - max_val=0, min_val={WIDTH{1'b1}}, max_idx=0, min_idx=0, all_equal=1
//  - States: ACCUM (collect samples), REPORT (hold record).
//  - Sample transfer: a sample transfers when in_valid && in_ready at the clk edge.
//    - cnt==0 (first sample): max=min=in_data, both idx=0, all_equal=1.
//    - cnt>0, compare in_data against max:
//      - g (in_data > max): max=in_data, max_idx=cnt.
//      - l or e: no change, so ties keep the earliest index.
//    - cnt>0, compare in_data against min:
//      - l (in_data < min): min=in_data, min_idx=cnt.
//      - g or e: no change.
//    - cnt>0, all_equal: cleared when in_data != max value before update. Never re-set within a frame.
//    - Comparison uses comparator cascade inputs l=0, e=1, g=0. The result is pure unsigned magnitude.
//  - Frame end: a transfer with cnt==FRAME_LEN-1 applies its update and then:
//    - cnt=0, state=REPORT, out_valid=1 on the following cycle.
//    - Latency: last sample edge -> out_valid high, 1 cycle.
//  - REPORT:
//    - in_ready=0.
//    - Record outputs are stable while out_valid=1 && !out_ready.
//    - out_valid && out_ready at the edge: out_valid=0, state=ACCUM, next frame starts fresh.
//    - in_ready rises the cycle after the handshake, so there is no same-cycle overlap.
//  - Between records, result outputs hold the last values; they are meaningful only while out_valid=1.
//  - clear (any state):
//    - At the next edge: cnt=0, state=ACCUM, out_valid=0. Any pending record is dropped.
//    - The sample offered in the clear cycle is NOT accepted, because in_ready=0.
//    - clear overrides a simultaneous out_ready handshake.
//  - Reset mid-frame or mid-REPORT: immediate return to reset values. No partial record is emitted.
//  - in_valid while in_ready=0: sample held by the producer, no state change.
//  - in_data at 0 and at all-ones must be handled; no wrap in cnt, since cnt never exceeds FRAME_LEN-1.
// TESTING (FRAME_LEN=4 unless noted)
//  1. Reset: assert reset asynchronously mid-cycle -> out_valid=0, in_ready=1, max=0, min=FF immediately.
//  2. Frame 5,200,3,200:
//     - out_valid 1 cycle after the 4th transfer.
//     - Record: max=200, max_idx=1 (first tie), min=3, min_idx=2, all_equal=0.
//  3. Frame 7,7,7,7 -> max=min=7, idx 0/0, all_equal=1. Frame 0,FF,FF,0 -> max=FF/1, min=0/0.
//  4. Backpressure:
//     - Hold out_ready=0 for 10 cycles with in_valid=1 -> record stable, in_ready=0, no sample lost.
//     - After the handshake, the next frame starts at idx 0.
//  5. clear:
//     - Send 2 samples, then pulse clear with in_valid=1 -> that sample is not taken.
//     - Next 4 samples 1,2,3,4 -> max=4/3, min=1/0.
//     - clear during REPORT -> out_valid=0 next cycle.
//  6. Random:
//     - 1000 frames, random in_valid/out_ready.
//     - Scoreboard checks max/min/idx/all_equal against a behavioural model.
//     - Also run FRAME_LEN=2 and FRAME_LEN=255.

Source files
------------

// File: rtl/frame_minmax_tracker_if.sv
// Stream/record bundle for frame_minmax_tracker.
//   clear      : synchronous abort request
//   in_valid   : sample present on in_data
//   in_data    : unsigned sample
//   in_ready   : tracker accepts a sample this cycle
//   out_valid  : result record valid
//   out_ready  : consumer accepts the record
//   max_val/max_idx, min_val/min_idx, all_equal : result record fields
interface frame_minmax_tracker_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDX_W = 8
) ();
    logic             clear;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] max_val;
    logic [IDX_W-1:0] max_idx;
    logic [WIDTH-1:0] min_val;
    logic [IDX_W-1:0] min_idx;
    logic             all_equal;

    // Producer/consumer side
    modport master (
        output clear, in_valid, in_data, out_ready,
        input  in_ready, out_valid, max_val, max_idx, min_val, min_idx, all_equal
    );

    // Tracker side
    modport slave (
        input  clear, in_valid, in_data, out_ready,
        output in_ready, out_valid, max_val, max_idx, min_val, min_idx, all_equal
    );
endinterface

// File: rtl/frame_minmax_tracker.sv
// Groups a valid/ready stream of unsigned samples into frames of FRAME_LEN
// samples and reports, per frame, the max/min values with the index of their
// first occurrence and whether all samples were equal.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : frame_minmax_tracker_if.slave (sample stream in, result record out,
//           synchronous clear). in_ready is combinational, all other outputs
//           are registered.
module frame_minmax_tracker #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned FRAME_LEN = 16,
    parameter int unsigned IDX_W     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    frame_minmax_tracker_if.slave bus
);

    typedef enum logic {
        ACCUM  = 1'b0,
        REPORT = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    // Magnitude comparator with l/e/g cascade; returns {l, e, g}.
    function automatic logic [2:0] cmp_lge(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             l_in,
        input logic             e_in,
        input logic             g_in
    );
        if (a < b) begin
            cmp_lge = 3'b100;
        end else if (a > b) begin
            cmp_lge = 3'b001;
        end else begin
            cmp_lge = {l_in, e_in, g_in};
        end
    endfunction

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic [WIDTH-1:0] min_q, min_d;
    logic [IDX_W-1:0] max_idx_q, max_idx_d;
    logic [IDX_W-1:0] min_idx_q, min_idx_d;
    logic             all_eq_q, all_eq_d;

    logic             in_ready_c;
    logic             xfer_c;
    logic [2:0]       cmp_max_c;
    logic [2:0]       cmp_min_c;

    // State and record registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ACCUM;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            max_q       <= '0;
            min_q       <= '1;
            max_idx_q   <= '0;
            min_idx_q   <= '0;
            all_eq_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            max_q       <= max_d;
            min_q       <= min_d;
            max_idx_q   <= max_idx_d;
            min_idx_q   <= min_idx_d;
            all_eq_q    <= all_eq_d;
        end
    end

    // Next-state, running max/min update and handshake logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        max_d       = max_q;
        min_d       = min_q;
        max_idx_d   = max_idx_q;
        min_idx_d   = min_idx_q;
        all_eq_d    = all_eq_q;

        // clear blocks acceptance in the same cycle so no sample slips in
        in_ready_c = (state_q == ACCUM) && !bus.clear;
        xfer_c     = bus.in_valid && in_ready_c;
        cmp_max_c  = cmp_lge(bus.in_data, max_q, 1'b0, 1'b1, 1'b0);
        cmp_min_c  = cmp_lge(bus.in_data, min_q, 1'b0, 1'b1, 1'b0);

        if (bus.clear) begin
            // Overrides any output handshake; record is dropped
            state_d     = ACCUM;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end else if (state_q == ACCUM) begin
            if (xfer_c) begin
                if (cnt_q == '0) begin
                    max_d     = bus.in_data;
                    min_d     = bus.in_data;
                    max_idx_d = '0;
                    min_idx_d = '0;
                    all_eq_d  = 1'b1;
                end else begin
                    // Strict compares so ties keep the earliest index
                    if (cmp_max_c[0]) begin
                        max_d     = bus.in_data;
                        max_idx_d = cnt_q;
                    end
                    if (cmp_min_c[2]) begin
                        min_d     = bus.in_data;
                        min_idx_d = cnt_q;
                    end
                    // Max before update equals sample 0 while all_equal holds
                    if (!cmp_max_c[1]) begin
                        all_eq_d = 1'b0;
                    end
                end

                if (cnt_q == LAST_IDX) begin
                    cnt_d       = '0;
                    state_d     = REPORT;
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
        end else begin
            if (bus.out_ready) begin
                out_valid_d = 1'b0;
                state_d     = ACCUM;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.max_val   = max_q;
    assign bus.max_idx   = max_idx_q;
    assign bus.min_val   = min_q;
    assign bus.min_idx   = min_idx_q;
    assign bus.all_equal = all_eq_q;

endmodule

// File: tb/tb_frame_minmax_tracker.sv
// Bench for frame_minmax_tracker: directed table of frames, hand-written
// backpressure/clear/reset sequences, and model-checked random streams for
// FRAME_LEN = 4, 2 and 255.
module tb_frame_minmax_tracker;

    logic clk = 1'b0;
    logic reset;
    logic reset_r;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    frame_minmax_tracker_if #(.WIDTH(8), .IDX_W(8)) dif ();

    frame_minmax_tracker #(
        .WIDTH    (8),
        .FRAME_LEN(4),
        .IDX_W    (8)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (dif)
    );

    typedef struct {
        logic [7:0] s0;
        logic [7:0] s1;
        logic [7:0] s2;
        logic [7:0] s3;
        logic [7:0] mx;
        logic [7:0] mxi;
        logic [7:0] mn;
        logic [7:0] mni;
        logic       ae;
    } vec_t;

    vec_t vecs [9];
    vec_t v_bp;
    vec_t v_bp2;
    vec_t v_clr;
    vec_t v_eq;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called on a negedge; returns on the negedge after the sample transferred.
    task automatic put(input logic [7:0] v);
        int n;
        n = 0;
        dif.in_valid = 1'b1;
        dif.in_data  = v;
        while (!dif.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL put_timeout: in_ready stuck at %0b expected 1", dif.in_ready);
        end
        @(negedge clk);
        dif.in_valid = 1'b0;
    endtask

    task automatic send_frame(input vec_t v);
        put(v.s0);
        put(v.s1);
        put(v.s2);
        chk("pre_last_out_valid", 32'(dif.out_valid), 32'd0);
        put(v.s3);
        chk("latency_out_valid", 32'(dif.out_valid), 32'd1);
        chk("report_in_ready", 32'(dif.in_ready), 32'd0);
    endtask

    task automatic check_rec(input vec_t v);
        chk("max_val", 32'(dif.max_val), 32'(v.mx));
        chk("max_idx", 32'(dif.max_idx), 32'(v.mxi));
        chk("min_val", 32'(dif.min_val), 32'(v.mn));
        chk("min_idx", 32'(dif.min_idx), 32'(v.mni));
        chk("all_equal", 32'(dif.all_equal), 32'(v.ae));
    endtask

    task automatic handshake();
        dif.out_ready = 1'b1;
        @(negedge clk);
        dif.out_ready = 1'b0;
        chk("hs_out_valid", 32'(dif.out_valid), 32'd0);
        chk("hs_in_ready", 32'(dif.in_ready), 32'd1);
    endtask

    // Random streams checked against a behavioural model
    for (genvar g = 0; g < 3; g++) begin : g_rnd
        localparam int FL  = (g == 0) ? 4 : ((g == 1) ? 2 : 255);
        localparam int NFR = (g == 2) ? 30 : 1000;

        frame_minmax_tracker_if #(.WIDTH(8), .IDX_W(8)) rif ();

        frame_minmax_tracker #(
            .WIDTH    (8),
            .FRAME_LEN(FL),
            .IDX_W    (8)
        ) u_rnd (
            .clk  (clk),
            .reset(reset_r),
            .bus  (rif)
        );

        int         n_total = 0;
        int         n_bad   = 0;
        logic       done    = 1'b0;
        int         m_cnt;
        int         m_maxi;
        int         m_mini;
        logic [7:0] m_max;
        logic [7:0] m_min;
        logic       m_ae;
        logic       pend;
        logic       pend_now;
        int         frames;
        int         cyc;
        logic [2:0] r;
        logic [7:0] d;

        initial begin
            rif.clear     = 1'b0;
            rif.in_valid  = 1'b0;
            rif.in_data   = '0;
            rif.out_ready = 1'b0;
            m_cnt  = 0;
            m_maxi = 0;
            m_mini = 0;
            m_max  = '0;
            m_min  = '1;
            m_ae   = 1'b1;
            pend   = 1'b0;
            frames = 0;
            cyc    = 0;
            @(negedge clk);
            while (reset_r !== 1'b0) @(negedge clk);
            @(negedge clk);
            while (frames < NFR && cyc < 40000) begin
                pend_now = pend;
                n_total++;
                if (rif.out_valid !== pend_now) begin
                    n_bad++;
                    $display("FAIL rnd_fl%0d_out_valid: got %0b expected %0b", FL, rif.out_valid, pend_now);
                end
                n_total++;
                if (rif.in_ready !== !pend_now) begin
                    n_bad++;
                    $display("FAIL rnd_fl%0d_in_ready: got %0b expected %0b", FL, rif.in_ready, !pend_now);
                end

                r = 3'($urandom_range(7));
                case (r)
                    3'd0:       d = 8'h00;
                    3'd1:       d = 8'hff;
                    3'd2, 3'd3: d = 8'($urandom_range(3));
                    default:    d = 8'($urandom);
                endcase
                rif.in_valid  = ($urandom_range(3) != 0);
                rif.in_data   = d;
                rif.out_ready = 1'($urandom_range(1));

                if (pend_now && rif.out_ready) begin
                    n_total++;
                    if ({rif.max_val, rif.max_idx, rif.min_val, rif.min_idx, rif.all_equal} !==
                        {m_max, 8'(m_maxi), m_min, 8'(m_mini), m_ae}) begin
                        n_bad++;
                        $display("FAIL rnd_fl%0d_rec: got max=%0h/%0d min=%0h/%0d eq=%0b expected max=%0h/%0d min=%0h/%0d eq=%0b",
                                 FL, rif.max_val, rif.max_idx, rif.min_val, rif.min_idx, rif.all_equal,
                                 m_max, m_maxi, m_min, m_mini, m_ae);
                    end
                    frames++;
                    pend = 1'b0;
                end

                if (!pend_now && rif.in_valid) begin
                    if (m_cnt == 0) begin
                        m_max  = d;
                        m_min  = d;
                        m_maxi = 0;
                        m_mini = 0;
                        m_ae   = 1'b1;
                    end else begin
                        if (d != m_max) m_ae = 1'b0;
                        if (d > m_max) begin
                            m_max  = d;
                            m_maxi = m_cnt;
                        end
                        if (d < m_min) begin
                            m_min  = d;
                            m_mini = m_cnt;
                        end
                    end
                    m_cnt++;
                    if (m_cnt == FL) begin
                        m_cnt = 0;
                        pend  = 1'b1;
                    end
                end

                @(negedge clk);
                cyc++;
            end
            if (frames < NFR) begin
                n_total++;
                n_bad++;
                $display("FAIL rnd_fl%0d_timeout: frames %0d expected %0d", FL, frames, NFR);
            end
            rif.in_valid  = 1'b0;
            rif.out_ready = 1'b0;
            done = 1'b1;
        end
    end

    initial begin
        int n;
        reset   = 1'b1;
        reset_r = 1'b1;
        dif.clear     = 1'b0;
        dif.in_valid  = 1'b0;
        dif.in_data   = '0;
        dif.out_ready = 1'b0;

        vecs[0] = '{8'd5,   8'd200, 8'd3,   8'd200, 8'd200, 8'd1, 8'd3,   8'd2, 1'b0};
        vecs[1] = '{8'd7,   8'd7,   8'd7,   8'd7,   8'd7,   8'd0, 8'd7,   8'd0, 1'b1};
        vecs[2] = '{8'd0,   8'hff,  8'hff,  8'd0,   8'hff,  8'd1, 8'd0,   8'd0, 1'b0};
        vecs[3] = '{8'hff,  8'hff,  8'hff,  8'hff,  8'hff,  8'd0, 8'hff,  8'd0, 1'b1};
        vecs[4] = '{8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0, 8'd0,   8'd0, 1'b1};
        vecs[5] = '{8'd9,   8'd8,   8'd7,   8'd6,   8'd9,   8'd0, 8'd6,   8'd3, 1'b0};
        vecs[6] = '{8'd1,   8'd2,   8'd3,   8'd4,   8'd4,   8'd3, 8'd1,   8'd0, 1'b0};
        vecs[7] = '{8'd3,   8'd1,   8'd3,   8'd1,   8'd3,   8'd0, 8'd1,   8'd1, 1'b0};
        vecs[8] = '{8'd7,   8'd7,   8'd7,   8'd8,   8'd8,   8'd3, 8'd7,   8'd0, 1'b0};
        v_bp    = '{8'd10,  8'd20,  8'd5,   8'd20,  8'd20,  8'd1, 8'd5,   8'd2, 1'b0};
        v_bp2   = '{8'd99,  8'd1,   8'd2,   8'd200, 8'd200, 8'd3, 8'd1,   8'd1, 1'b0};
        v_clr   = '{8'd1,   8'd2,   8'd3,   8'd4,   8'd4,   8'd3, 8'd1,   8'd0, 1'b0};
        v_eq    = '{8'd9,   8'd9,   8'd9,   8'd9,   8'd9,   8'd0, 8'd9,   8'd0, 1'b1};

        repeat (2) @(negedge clk);
        reset   = 1'b0;
        reset_r = 1'b0;
        #1;
        chk("rst_out_valid", 32'(dif.out_valid), 32'd0);
        chk("rst_in_ready", 32'(dif.in_ready), 32'd1);
        chk("rst_max_val", 32'(dif.max_val), 32'h00);
        chk("rst_min_val", 32'(dif.min_val), 32'hff);
        chk("rst_max_idx", 32'(dif.max_idx), 32'd0);
        chk("rst_min_idx", 32'(dif.min_idx), 32'd0);
        chk("rst_all_equal", 32'(dif.all_equal), 32'd1);
        @(negedge clk);

        // Directed frame table
        for (int i = 0; i < 9; i++) begin
            send_frame(vecs[i]);
            check_rec(vecs[i]);
            handshake();
        end

        // Backpressure: record held, producer stalled with a pending sample
        send_frame(v_bp);
        dif.in_valid = 1'b1;
        dif.in_data  = 8'd99;
        repeat (10) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(dif.out_valid), 32'd1);
            chk("bp_in_ready", 32'(dif.in_ready), 32'd0);
            chk("bp_max_val", 32'(dif.max_val), 32'd20);
            chk("bp_min_idx", 32'(dif.min_idx), 32'd2);
        end
        check_rec(v_bp);
        dif.out_ready = 1'b1;
        @(negedge clk);
        dif.out_ready = 1'b0;
        chk("bp_hs_out_valid", 32'(dif.out_valid), 32'd0);
        chk("bp_hs_in_ready", 32'(dif.in_ready), 32'd1);
        @(negedge clk);
        dif.in_valid = 1'b0;
        put(v_bp2.s1);
        put(v_bp2.s2);
        chk("bp2_pre_out_valid", 32'(dif.out_valid), 32'd0);
        put(v_bp2.s3);
        chk("bp2_out_valid", 32'(dif.out_valid), 32'd1);
        check_rec(v_bp2);
        handshake();

        // clear mid-frame: offered sample is refused and the frame restarts
        put(8'd50);
        put(8'd60);
        dif.in_valid = 1'b1;
        dif.in_data  = 8'd250;
        dif.clear    = 1'b1;
        #1;
        chk("clr_in_ready", 32'(dif.in_ready), 32'd0);
        @(negedge clk);
        dif.clear    = 1'b0;
        dif.in_valid = 1'b0;
        #1;
        chk("clr_after_in_ready", 32'(dif.in_ready), 32'd1);
        send_frame(v_clr);
        check_rec(v_clr);

        // clear in REPORT with a simultaneous out_ready drops the record
        dif.out_ready = 1'b1;
        dif.clear     = 1'b1;
        #1;
        chk("clr_rep_in_ready", 32'(dif.in_ready), 32'd0);
        @(negedge clk);
        dif.clear     = 1'b0;
        dif.out_ready = 1'b0;
        #1;
        chk("clr_rep_out_valid", 32'(dif.out_valid), 32'd0);
        chk("clr_rep_in_ready2", 32'(dif.in_ready), 32'd1);
        send_frame(v_eq);
        check_rec(v_eq);
        handshake();

        // Asynchronous reset mid-cycle while a record is pending
        send_frame(vecs[0]);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_out_valid", 32'(dif.out_valid), 32'd0);
        chk("arst_in_ready", 32'(dif.in_ready), 32'd1);
        chk("arst_max_val", 32'(dif.max_val), 32'h00);
        chk("arst_min_val", 32'(dif.min_val), 32'hff);
        chk("arst_all_equal", 32'(dif.all_equal), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send_frame(vecs[5]);
        check_rec(vecs[5]);
        handshake();

        n = 0;
        while (!(g_rnd[0].done && g_rnd[1].done && g_rnd[2].done) && n < 50000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50000) begin
            total++;
            bad++;
            $display("FAIL rnd_wait_timeout: random streams still running after %0d cycles", n);
        end

        total = total + g_rnd[0].n_total + g_rnd[1].n_total + g_rnd[2].n_total;
        bad   = bad + g_rnd[0].n_bad + g_rnd[1].n_bad + g_rnd[2].n_bad;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
